aes_stream_top: RTL and testbench
=================================

# aes_stream_top

Parametrised streaming wrapper around `AES_top`. It adds the following around the existing core:
- valid/ready input and output handshakes,
- a runtime-loadable key (the hardwired key becomes the reset default),
- ECB and CTR modes,
- an output FIFO with credit-based issue, so results are never dropped,
- a sticky ECB round-trip self-check using the core's decrypt output.

It is the top-level block between the system bus and the AES core.

## Interface
Parameters:
- `DEFAULT_KEY`, 128'h100F0E0D0C0B0A090807060504030201, key after reset.
- `CORE_LATENCY`, 1, edges from core input change to valid `cipher_text`/`decrypted_plain_text`. Must be ≥1.
- `FIFO_DEPTH`, 4, output FIFO entries. Power of two, ≥2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input block valid.
- `in_ready`  out  1  wrapper accepts block.
- `in_data`  in  128  plaintext (ECB) or data to XOR (CTR).
- `cfg_valid`  in  1  key/mode load request. Hold until `cfg_ready`.
- `cfg_ready`  out  1  load accepted this cycle.
- `cfg_key`  in  128  new key.
- `cfg_mode`  in  1  0 = ECB, 1 = CTR.
- `cfg_iv`  in  128  CTR initial counter.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  128  result block.
- `selfcheck_err`  out  1  sticky ECB decrypt mismatch.
- `busy`  out  1  blocks in flight or FIFO non-empty.

## Operation
- **Registers:** `key_q`, `mode_q`, `ctr_q` (128-bit), core input register `core_pt`, a tag shift line of `CORE_LATENCY` stages, and the FIFO.
- **Tag line:** each stage holds {valid, `in_data`, `mode`}.
- **Reset values:** `key_q` = `DEFAULT_KEY`, `mode_q` = ECB, `ctr_q` = 0, all tags invalid, FIFO empty.
- **Outputs during reset:** `out_valid` = 0, `out_data` = 0, `selfcheck_err` = 0, `busy` = 0, `in_ready` = 0, `cfg_ready` = 0.
- **in_fire** = `in_valid & in_ready`. On in_fire, `core_pt` is loaded with:
  - `in_data` in ECB,
  - `ctr_q` in CTR; `ctr_q` increments by 1 modulo 2^128 (all-ones wraps to 0).
- **Core connection:** the core sees `key_q` and `core_pt`.
- **Credit:** `in_ready` = (state == RUN) & (inflight + fifo_count < `FIFO_DEPTH`). `inflight` counts valid tags. The FIFO therefore can never overflow.
- **Retire:** when the last tag stage is valid, the FIFO is written with:
  - `cipher_text` in ECB,
  - `cipher_text ^ tag.data` in CTR.
- **Self-check (ECB tags only):** if `decrypted_plain_text` ≠ `tag.data` at retire, set `selfcheck_err`. It clears only on reset.
- **FSM:**
  - **RUN:** default. `cfg_valid` → DRAIN. `in_ready` drops in the same cycle.
  - **DRAIN:** wait until `inflight` == 0 → LOAD. The FIFO may still hold entries; they drain normally.
  - **LOAD:** one cycle. `cfg_ready` = 1; `key_q` ← `cfg_key`, `mode_q` ← `cfg_mode`, `ctr_q` ← `cfg_iv`. Then → RUN.
- **`busy`** = (`inflight` ≠ 0) | (fifo_count ≠ 0).

## Timing
- **Latency:** in_fire at edge E makes `out_valid` high after edge E + `CORE_LATENCY` + 1 when the FIFO was empty.
- **Throughput:** 1 block/cycle while `out_ready` = 1.
- **FIFO:** first-word fall-through. `out_data` is stable while `out_valid` & !`out_ready`. Simultaneous write and read on a full FIFO is allowed and the count is unchanged. A write to an empty FIFO gives `out_valid` on the next cycle.
- **Backpressure:** with `out_ready` = 0, at most `FIFO_DEPTH` blocks are accepted, then `in_ready` stays 0.
- **Config timing:** `cfg_valid` with zero in flight reaches RUN→DRAIN→LOAD, so `cfg_ready` comes 2 cycles after `cfg_valid` rises. In-flight blocks always complete with the old key and mode.
- **Concurrent request:** `cfg_valid` and `in_valid` in the same RUN cycle: config wins and no block is accepted.
- **Reset mid-operation:** immediately empties the tags and FIFO and restores all defaults. No partial output is emitted.

## Test plan
- **ECB vector:** load key 000102030405060708090a0b0c0d0e0f, mode ECB; send 00112233445566778899aabbccddeeff → `out_data` 69c4e0d86a7b0430d8cdb78070b4c55a after `CORE_LATENCY`+1 cycles, `selfcheck_err` = 0.
- **CTR round trip:** key as above, iv ffffffffffffffffffffffffffffffff; stream 3 blocks, reload the same iv, send the outputs back → the original blocks are recovered. The second block's counter wrapped to 0.
- **Backpressure:** hold `out_ready` = 0 and drive `in_valid` = 1 continuously → exactly `FIFO_DEPTH` accepted, then `in_ready` = 0. Release → outputs come out in order with no loss or duplication.
- **Key change mid-stream:** issue `cfg_valid` with 1 block in flight → that block completes under the old key, `cfg_ready` pulses once, the next block uses the new key.
- **Reset:** assert `rst` with the FIFO half full → `out_valid` = 0, `busy` = 0, `key_q` = `DEFAULT_KEY`, and the next ECB block is encrypted with the default key.
- **Self-check:** force a corrupted `decrypted_plain_text` on one retire → `selfcheck_err` rises and stays high until `rst`.

Source files
------------

// File: rtl/aes_stream_top.sv
// Streaming AES-128 wrapper: valid/ready in/out, runtime key/mode load,
// ECB and CTR modes, credit-limited output FIFO and ECB decrypt self-check.
// AES_top is a combinational AES-128 encrypt/decrypt datapath with LAT output
// register stages. decrypted_plain_text is the decryption of its own cipher_text.

module AES_top #(
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [127:0] plain_text,
  output logic [127:0] cipher_text,
  output logic [127:0] decrypted_plain_text
);
  typedef logic [10:0][127:0] rk_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  // State byte 4c+r (row r, column c) sits at bits [127-8*(4c+r) -: 8]
  function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? 4*((c+4-r)%4)+r : 4*((c+r)%4)+r;
        o[127-8*(4*c+r) -: 8] = inv ? isb(s[127-8*src -: 8]) : sb(s[127-8*src -: 8]);
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv ?
          gmul(a[r], 8'd14) ^ gmul(a[(r+1)%4], 8'd11) ^ gmul(a[(r+2)%4], 8'd13) ^ gmul(a[(r+3)%4], 8'd9) :
          xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic rk_t expand(input logic [127:0] k);
    rk_t         t;
    logic [31:0] w;
    logic [7:0]  rc;
    t[0] = k;
    rc   = 8'h01;
    for (int r = 1; r < 11; r++) begin
      w = t[r-1][31:0];
      w = {sb(w[23:16]) ^ rc, sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
      t[r][127:96] = t[r-1][127:96] ^ w;
      t[r][95:64]  = t[r-1][95:64]  ^ t[r][127:96];
      t[r][63:32]  = t[r-1][63:32]  ^ t[r][95:64];
      t[r][31:0]   = t[r-1][31:0]   ^ t[r][63:32];
      rc = xt(rc);
    end
    return t;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input rk_t rk);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < 10; r++) s = mix(sub_shift(s, 1'b0), 1'b0) ^ rk[r];
    return sub_shift(s, 1'b0) ^ rk[10];
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct, input rk_t rk);
    logic [127:0] s;
    s = ct ^ rk[10];
    for (int r = 9; r > 0; r--) s = mix(sub_shift(s, 1'b1) ^ rk[r], 1'b1);
    return sub_shift(s, 1'b1) ^ rk[0];
  endfunction

  rk_t                     rks;
  logic [127:0]            ct_c, dec_c;
  logic [LAT-1:0][127:0]   ct_q, dec_q;

  assign rks   = expand(key);
  assign ct_c  = enc(plain_text, rks);
  assign dec_c = dec(ct_c, rks);

  // Output pipeline: results valid LAT edges after the inputs change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_q  <= '0;
      dec_q <= '0;
    end else begin
      ct_q[0]  <= ct_c;
      dec_q[0] <= dec_c;
      for (int k = 1; k < LAT; k++) begin
        ct_q[k]  <= ct_q[k-1];
        dec_q[k] <= dec_q[k-1];
      end
    end
  end

  assign cipher_text          = ct_q[LAT-1];
  assign decrypted_plain_text = dec_q[LAT-1];
endmodule

module aes_stream_top #(
  parameter logic [127:0] DEFAULT_KEY  = 128'h100F0E0D0C0B0A090807060504030201,
  parameter int           CORE_LATENCY = 1,
  parameter int           FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [127:0] cfg_key,
  input  logic         cfg_mode,
  input  logic [127:0] cfg_iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         selfcheck_err,
  output logic         busy
);
  localparam int L  = CORE_LATENCY;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + L + 2) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_e;

  state_e                        state_q, state_d;
  logic [127:0]                  key_q, ctr_q, core_pt_q;
  logic                          mode_q;
  // Stage 0 travels with core_pt_q; stage L lines up with the core outputs
  logic [L:0]                    vld_pipe;
  logic [L:0][127:0]             tdat_q;
  logic [L:0]                    tmode_q;
  logic [FIFO_DEPTH-1:0][127:0]  mem_q;
  logic [AW-1:0]                 wptr_q, rptr_q;
  logic [CW-1:0]                 cnt_q, inflight;
  logic                          sc_err_q, in_fire, retire, rd;
  logic [127:0]                  core_ct, core_dec, res;

  AES_top #(.LAT(L)) u_core (
    .clk                  (clk),
    .rst                  (rst),
    .key                  (key_q),
    .plain_text           (core_pt_q),
    .cipher_text          (core_ct),
    .decrypted_plain_text (core_dec)
  );

  // Count blocks that have been accepted but not yet written to the FIFO
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= L; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  // FSM next state and handshake outputs; config beats data in RUN
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = !rst && !cfg_valid && ((inflight + cnt_q) < CW'(FIFO_DEPTH));
        if (cfg_valid) state_d = DRAIN;
      end
      DRAIN: if (inflight == '0) state_d = LOAD;
      LOAD: begin
        cfg_ready = 1'b1;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign in_fire   = in_valid && in_ready;
  assign retire    = vld_pipe[L];
  assign res       = tmode_q[L] ? (core_ct ^ tdat_q[L]) : core_ct;
  assign out_valid = (cnt_q != '0);
  assign rd        = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign busy      = (inflight != '0) || (cnt_q != '0);
  assign selfcheck_err = sc_err_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Key/mode/counter, core input register and self-check flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= DEFAULT_KEY;
      mode_q    <= 1'b0;
      ctr_q     <= '0;
      core_pt_q <= '0;
      sc_err_q  <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        key_q  <= cfg_key;
        mode_q <= cfg_mode;
        ctr_q  <= cfg_iv;
      end else if (in_fire) begin
        core_pt_q <= mode_q ? ctr_q : in_data;
        if (mode_q) ctr_q <= ctr_q + 128'd1;
      end
      if (retire && !tmode_q[L] && (core_dec != tdat_q[L])) sc_err_q <= 1'b1;
    end
  end

  // Tag valid shift line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[L-1:0], in_fire};
  end

  // Tag payload rides alongside; only meaningful where vld_pipe is set
  always_ff @(posedge clk) begin
    tdat_q  <= {tdat_q[L-1:0], in_data};
    tmode_q <= {tmode_q[L-1:0], mode_q};
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (retire) mem_q[wptr_q] <= res;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (retire) wptr_q <= wptr_q + 1'b1;
      if (rd)     rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(retire) - CW'(rd);
    end
  end
endmodule

// File: tb/tb_aes_stream_top.sv
// Scoreboard bench for aes_stream_top with a table-driven AES-128 model.
module tb_aes_stream_top;
  localparam logic [127:0] DKEY = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam int L = 1;
  localparam int D = 4;

  logic         clk = 0, rst = 1;
  logic         in_valid = 0, in_ready, cfg_valid = 0, cfg_ready, cfg_mode = 0;
  logic         out_valid, out_ready = 0, selfcheck_err, busy;
  logic [127:0] in_data = '0, cfg_key = '0, cfg_iv = '0, out_data;

  aes_stream_top #(.DEFAULT_KEY(DKEY), .CORE_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_mode(cfg_mode),
    .cfg_iv(cfg_iv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .selfcheck_err(selfcheck_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int           checks = 0, failures = 0;
  logic [7:0]   sbox [256];
  logic [127:0] exp_q[$], got_q[$];
  logic [127:0] m_key = DKEY, m_ctr = '0;
  logic         m_mode = 0;
  int           n_fire = 0, n_cfg = 0, rdy_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from brute-force inverse search plus the bitwise affine map
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv, s, c;
      inv = 0; c = 8'h63;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[a] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [4][4], k [4][4], t [4][4], a [4];
    logic [7:0]   rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) begin
      k[r][c] = key[127-8*(4*c+r) -: 8];
      s[r][c] = pt[127-8*(4*c+r) -: 8] ^ k[r][c];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++) a[r] = sbox[k[(r+1)%4][3]];
      a[0] ^= rc;
      for (int r = 0; r < 4; r++) k[r][0] ^= a[r];
      for (int c = 1; c < 4; c++) for (int r = 0; r < 4; r++) k[r][c] ^= k[r][c-1];
      rc = gm(rc, 8'h02);
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][c] = sbox[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = t[r][c];
        for (int r = 0; r < 4; r++)
          s[r][c] = (rnd == 10) ? a[r] :
                    gm(a[r], 8'h02) ^ gm(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] ^= k[r][c];
    end
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = 1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 0;
    endcase
  end

  // Reference model: tracks key/mode/counter and pushes expected results on accept
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_key = DKEY; m_mode = 0; m_ctr = '0;
      exp_q.delete();
    end else begin
      if (cfg_ready) begin
        m_key = cfg_key; m_mode = cfg_mode; m_ctr = cfg_iv; n_cfg++;
      end
      if (in_valid && in_ready) begin
        if (m_mode) begin
          exp_q.push_back(aes_enc(m_key, m_ctr) ^ in_data);
          m_ctr = m_ctr + 1;
        end else exp_q.push_back(aes_enc(m_key, in_data));
        n_fire++;
      end
    end
  end

  // Monitor: compares every delivered block and head stability under stall
  logic         hold = 0;
  logic [127:0] hold_d = '0;
  initial forever begin
    @(negedge clk);
    if (rst) hold = 0;
    else begin
      if (hold && out_valid) chk("head_stable", out_data, hold_d);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out: got %h with nothing expected", out_data);
        end else chk("out_data", out_data, exp_q.pop_front());
        got_q.push_back(out_data);
      end
      hold = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    in_valid = 1; in_data = d;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic cfg(input logic [127:0] k, input logic m, input logic [127:0] iv, output int lat);
    cfg_valid = 1; cfg_key = k; cfg_mode = m; cfg_iv = iv; lat = 0;
    do begin @(negedge clk); lat++; end while (!cfg_ready && lat < 100);
    if (!cfg_ready) begin
      checks++; failures++;
      $display("FAIL cfg_timeout: cfg_ready never rose");
    end
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin step(1); n++; end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      failures++;
      $display("FAIL drain: pending=%0d busy=%0b", exp_q.size(), busy);
    end
  endtask

  initial begin
    int lat, k, f0, c0;
    logic [127:0] p [3];
    logic [127:0] c [3];
    build_sbox();
    step(3);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_selfcheck", selfcheck_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_key", dut.key_q, DKEY);
    step(1);
    rst = 0;

    // Random ECB traffic under the default key with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 24; i++) begin
      send({$urandom, $urandom, $urandom, $urandom});
      step($urandom_range(0, 2));
    end
    drain();
    chk("selfcheck_clean", selfcheck_err, 0);

    // Known-answer ECB vector with latency and config timing
    c0 = n_cfg;
    cfg(K1, 0, '0, lat);
    chk("cfg_latency", lat, 3);
    chk("cfg_pulses", n_cfg - c0, 1);
    send(128'h00112233445566778899aabbccddeeff);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 50);
    chk("ecb_latency", k, L + 2);
    chk("ecb_vector", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    step(1);
    drain();
    chk("ecb_selfcheck", selfcheck_err, 0);

    // CTR round trip with the counter wrapping from all-ones
    cfg(K1, 1, '1, lat);
    got_q.delete();
    for (int i = 0; i < 3; i++) begin p[i] = {$urandom, $urandom, $urandom, $urandom}; send(p[i]); end
    drain();
    for (int i = 0; i < 3; i++) c[i] = got_q[i];
    cfg(K1, 1, '1, lat);
    got_q.delete();
    for (int i = 0; i < 3; i++) send(c[i]);
    drain();
    for (int i = 0; i < 3; i++) chk($sformatf("ctr_roundtrip%0d", i), got_q[i], p[i]);

    // Backpressure: stalled consumer caps acceptance at FIFO_DEPTH
    cfg(K1, 0, '0, lat);
    rdy_mode = 2;
    step(2);
    f0 = n_fire;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step(1);
    end
    chk("bp_accepted", n_fire - f0, D);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 0;
    rdy_mode = 1;
    step(20);
    drain();

    // Key change with one block in flight
    c0 = n_cfg;
    send(128'hdeadbeef_00000000_cafef00d_12345678);
    cfg({$urandom, $urandom, $urandom, $urandom}, 0, '0, lat);
    send(128'hdeadbeef_00000000_cafef00d_12345678);
    drain();
    step(3);
    chk("keychg_pulses", n_cfg - c0, 1);

    // Concurrent config and data request: config wins
    in_valid = 1; in_data = 128'h1; cfg_valid = 1; cfg_key = K1; cfg_mode = 0;
    f0 = n_fire;
    @(negedge clk);
    chk("concurrent_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 0;
    k = 0;
    while (!cfg_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    cfg_valid = 0;
    chk("concurrent_no_fire", n_fire - f0, 0);

    // Reset with the FIFO half full
    rdy_mode = 2;
    step(1);
    send(128'h11); send(128'h22);
    step(4);
    chk("half_full_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_key", dut.key_q, DKEY);
    step(2);
    rst = 0;
    rdy_mode = 0;
    send(128'h00112233445566778899aabbccddeeff);
    drain();

    // Corrupted decrypt path trips the sticky self-check
    chk("sc_before", selfcheck_err, 0);
    force dut.core_dec = 128'h0;
    send(128'h0123456789abcdef0123456789abcdef);
    drain();
    release dut.core_dec;
    chk("sc_set", selfcheck_err, 1);
    send(128'h5);
    drain();
    chk("sc_sticky", selfcheck_err, 1);
    rst = 1;
    #1;
    chk("sc_cleared", selfcheck_err, 0);
    step(2);
    rst = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
